// File: rtl/cam_access_ctrl.sv
`default_nettype none
//==============================================================================
// Module  : cam_access_ctrl
// Brief   : Two-client round-robin sequencer/arbiter for the credential-store
//           CAM with slot-occupancy tracking. Optional Busy watchdog is
//           enabled by defining CAM_TIMEOUT_EN.
// Revision: 1.0 - initial release
//==============================================================================
module cam_access_ctrl #(
  parameter int DATA_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Rest,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_op,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic                    rsp_hit,
  output logic [ADDR_WIDTH-1:0]   rsp_addr,
  output logic                    rsp_full,
  output logic                    rsp_err,
  output logic                    cam_wr_en,
  output logic [ADDR_WIDTH-1:0]   cam_wr_addr,
  output logic [DATA_WIDTH-1:0]   cam_data_in,
  output logic [DATA_WIDTH-1:0]   cam_cmp_din,
  input  logic                    cam_busy,
  input  logic                    cam_match,
  input  logic [ADDR_WIDTH-1:0]   cam_match_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  rr_q;
  logic                  gnt_q;
  logic                  op_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [DATA_WIDTH-1:0] cmp_din_q;
  logic [ADDR_WIDTH-1:0] slot_q;
  logic [DEPTH-1:0]      occ_q;
  logic [1:0]            rsp_valid_q;
  logic                  rsp_hit_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic                  rsp_full_q;
  logic                  rsp_err_q;

  logic                  gnt_sel;
  logic                  op_sel;
  logic [DATA_WIDTH-1:0] key_sel;
  logic                  hs;
  logic [1:0]            gnt_oh;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  occ_full;
  logic                  wr_fire;
  logic                  match_ok;
  logic                  tmo_hit;

  // A lone requester wins outright; contention is settled by rr_q.
  always_comb begin
    gnt_sel = rr_q;
    if (req_valid == 2'b01) begin
      gnt_sel = 1'b0;
    end else if (req_valid == 2'b10) begin
      gnt_sel = 1'b1;
    end
  end

  assign key_sel   = gnt_sel ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
  assign op_sel    = req_op[gnt_sel];
  assign hs        = Rest && (state_q == S_IDLE) && (|req_valid);
  assign req_ready = hs ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign gnt_oh    = gnt_q ? 2'b10 : 2'b01;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_idx = ADDR_WIDTH'(i);
      end
    end
  end

  assign occ_full = &occ_q;
  assign wr_fire  = (state_q == S_ISSUE) && !cam_busy && op_q && !occ_full;
  // Stale CAM contents (including never-written zero entries) are masked here.
  assign match_ok = cam_match && occ_q[cam_match_addr];

  assign cam_wr_en   = wr_fire;
  assign cam_wr_addr = wr_fire ? free_idx : '0;
  assign cam_data_in = wr_fire ? key_q : '0;
  assign cam_cmp_din = cmp_din_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_full  = rsp_full_q;
  assign rsp_err   = rsp_err_q;

`ifdef CAM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_q;

  assign tmo_hit = cam_busy && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive Busy cycles; any non-busy cycle or state change restarts it.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      tmo_q <= '0;
    end else if ((state_q == S_ISSUE || state_q == S_WAIT) && cam_busy && !tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      op_q        <= 1'b0;
      key_q       <= '0;
      cmp_din_q   <= '0;
      slot_q      <= '0;
      occ_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_full_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hs) begin
            op_q    <= op_sel;
            key_q   <= key_sel;
            gnt_q   <= gnt_sel;
            rr_q    <= ~gnt_sel;
            state_q <= S_ISSUE;
            // Compare key is loaded early so it is stable for the whole ISSUE cycle.
            if (!op_sel) begin
              cmp_din_q <= key_sel;
            end
          end
        end

        S_ISSUE: begin
          if (tmo_hit) begin
            rsp_valid_q <= gnt_oh;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else if (!cam_busy) begin
            if (op_q && occ_full) begin
              rsp_valid_q <= gnt_oh;
              rsp_full_q  <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              if (op_q) begin
                occ_q[free_idx] <= 1'b1;
                slot_q          <= free_idx;
              end
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (tmo_hit) begin
            rsp_valid_q <= gnt_oh;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else if (!cam_busy) begin
            rsp_valid_q <= gnt_oh;
            state_q     <= S_RESP;
            if (op_q) begin
              rsp_hit_q  <= 1'b1;
              rsp_addr_q <= slot_q;
            end else if (match_ok) begin
              rsp_hit_q  <= 1'b1;
              rsp_addr_q <= cam_match_addr;
            end else begin
              rsp_hit_q  <= 1'b0;
              rsp_addr_q <= '0;
            end
          end
        end

        S_RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_hit_q   <= 1'b0;
          rsp_addr_q  <= '0;
          rsp_full_q  <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cam_access_ctrl.md
Name: cam_access_ctrl

Overview:
- Sequencer and arbiter in front of the CAM, for the credential store.
- Two clients (port 0 enrollment, port 1 verification) issue store or lookup requests.
- The block round-robins between them, allocates free CAM slots, drives the CAM write and compare ports, honours CAM Busy, and returns one response per request.
- Tracks slot occupancy so unwritten (zero) entries never report a hit.

Parameters:
- DATA_WIDTH, 4, width of stored and compared key
- ADDR_WIDTH, 2, CAM address width; depth = 2**ADDR_WIDTH
- TIMEOUT_CYCLES, 16, Busy watchdog limit (used only with the optional feature)

Ports:
- Clk  in  1  clock, rising edge
- Rest  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, one bit per client
- req_op  in  2  per client: 0 = lookup, 1 = store
- req_data  in  2*DATA_WIDTH  per-client key; client 0 in [DATA_WIDTH-1:0]
- req_ready  out  2  one-hot grant/accept
- rsp_valid  out  2  one-cycle response pulse to the granted client
- rsp_hit  out  1  lookup hit, or store success
- rsp_addr  out  ADDR_WIDTH  matched or allocated slot
- rsp_full  out  1  store rejected, CAM full
- rsp_err  out  1  watchdog abort
- cam_wr_en  out  1  CAM Writ_Enable
- cam_wr_addr  out  ADDR_WIDTH  CAM WR_Addr
- cam_data_in  out  DATA_WIDTH  CAM Data_IN
- cam_cmp_din  out  DATA_WIDTH  CAM CMP_Din
- cam_busy  in  1  CAM Busy
- cam_match  in  1  CAM Match
- cam_match_addr  in  ADDR_WIDTH  CAM Match_Addr

Behaviour:
- Clock and reset: one clock, Clk. Rest is asynchronous, active-low.
- Reset state:
  - FSM = IDLE, rr_ptr = 0, occupancy bitmap = all 0.
  - All outputs 0, including req_ready, rsp_*, cam_wr_en, cam_wr_addr, cam_data_in and cam_cmp_din.
  - A reset mid-operation aborts the request with no response; CAM contents are untouched but masked by the cleared bitmap.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational, one-hot.
  - Both clients valid: grant client rr_ptr. One valid: grant that client.
  - On the handshake, latch op, data and grant id; set rr_ptr to the other client; go to ISSUE.
  - The losing client holds req_valid and is served next.
- ISSUE:
  - Stay while cam_busy=1.
  - Store with bitmap full: no CAM access; go to RESP with rsp_full=1, rsp_hit=0.
  - Store otherwise: for exactly one cycle drive cam_wr_en=1, cam_wr_addr = lowest-index free slot, cam_data_in = key. Set that bitmap bit and record the slot; go to WAIT.
  - Lookup: drive cam_cmp_din = key, held through WAIT; go to WAIT.
- WAIT:
  - Stay while cam_busy=1.
  - On the first cycle with cam_busy=0, sample cam_match and cam_match_addr; go to RESP.
  - Lookup hit = cam_match AND bitmap[cam_match_addr]. rsp_addr = cam_match_addr on a hit, else 0.
  - Store: rsp_hit=1, rsp_addr = allocated slot.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle, with rsp_hit, rsp_addr, rsp_full and rsp_err valid in that cycle. Go to IDLE.
  - rsp_* fields return to 0 afterwards.
- Only one request is outstanding; req_ready=0 outside IDLE.
- Minimum latency: handshake at cycle N, rsp_valid at N+3 when the CAM is never busy.
- Duplicate keys are not checked on store. Lookups report the CAM's priority match, masked by the bitmap.
- cam_cmp_din holds its last value when idle. cam_wr_en is never asserted outside ISSUE.

Optional Feature:
- Macro: CAM_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE and WAIT and clears on state change.
  - If cam_busy stays 1 for TIMEOUT_CYCLES consecutive cycles, go to RESP with rsp_err=1, rsp_hit=0.
  - A store that has not yet written leaves the bitmap unchanged.
- Undefined: no counter; rsp_err is tied to 0; the FSM waits on Busy indefinitely.

Test Plan:
- Reset, client 0 stores 4'hA with Busy=0 -> cam_wr_en for one cycle with addr 0, data A; rsp_valid[0] 3 cycles after the handshake; rsp_hit=1, rsp_addr=0.
- After the previous store, client 1 looks up 4'hA (CAM returns match, addr 0) -> rsp_valid[1], hit=1, addr=0. Lookup of 4'h0 with CAM match at addr 1 (unwritten) -> hit=0.
- Four stores 1,2,3,4, then a fifth store 5 -> slots 0..3 allocated in order; fifth response has full=1, hit=0, and no cam_wr_en.
- Both clients valid continuously for 4 requests -> grants alternate 0,1,0,1; each rsp_valid goes to the matching client.
- cam_busy held 5 cycles during ISSUE -> no cam_wr_en until Busy drops; response delayed by 5 cycles. Rest pulsed low in WAIT -> all outputs 0 immediately, bitmap cleared, no rsp_valid.
- With CAM_TIMEOUT_EN and TIMEOUT_CYCLES=16, Busy stuck at 1 -> rsp_err=1 after 16 cycles; the next request is accepted.
